uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter peripheral on the core data bus, decoded alongside the timer registers in the 0x0000_2010–0x0000_201F window. It takes the same registered bus signals as the timer block: chip-select, write-enable, byte mask, address and write data. It buffers bytes in a small FIFO and serialises them 8N1 on `tx_o` at a programmable baud rate. A level interrupt drives one `fast_irq_i` line of the core.

---
 rtl/uart_tx_periph_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx_periph.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter peripheral.
// Contents: register byte offsets within the 16-byte window, STATUS bit
// positions, and the transmit FSM state type.
package uart_tx_periph_pkg;

    localparam logic [3:0] UART_TXDATA  = 4'h0;
    localparam logic [3:0] UART_STATUS  = 4'h4;
    localparam logic [3:0] UART_BAUDDIV = 4'h8;
    localparam logic [3:0] UART_IRQEN   = 4'hC;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   push_i, din_i    write strobe and byte; ignored when full
//   pop_i, dout_o    read strobe; dout_o shows the head entry (first-word fall-through)
//   empty_o, full_o  occupancy flags
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign dout_o  = mem_q[rptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) wptr_d = wptr_q + AW'(1);
        if (pop_ok)  rptr_d = rptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and level interrupt.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   csb_i, wen_i         active-low chip select / write enable (registered upstream)
//   addr_i               byte offset, [3:2] selects TXDATA/STATUS/BAUDDIV/IRQEN
//   data_i, wmask_i      write data and byte-lane mask
//   data_o               combinational read data, 0 when deselected
//   tx_o                 serial output, idle high
//   irq_o                registered "done" interrupt (enabled, FIFO empty, FSM idle)
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        csb_i,
    input  logic        wen_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  wmask_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam logic [1:0] SEL_TXDATA  = UART_TXDATA[3:2];
    localparam logic [1:0] SEL_STATUS  = UART_STATUS[3:2];
    localparam logic [1:0] SEL_BAUDDIV = UART_BAUDDIV[3:2];
    localparam logic [1:0] SEL_IRQEN   = UART_IRQEN[3:2];

    logic [1:0]  sel;
    logic        wr_en, push, pop;
    logic [7:0]  fifo_dout;
    logic        fifo_empty, fifo_full;

    logic [15:0] div_q, div_d;
    logic        irqen_q, irqen_d;
    logic        ovf_q, ovf_d;
    logic        irq_q, irq_d;

    uart_state_e state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        baud_done, bit_start, data_bit_end, busy;

    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], data_i[31:16]};

    assign sel   = addr_i[3:2];
    assign wr_en = ~csb_i & ~wen_i;
    assign push  = wr_en & (sel == SEL_TXDATA) & wmask_i[0];

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (data_i[7:0]),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Register writes; a dropped push sets overflow after any clear so set wins.
    always_comb begin
        div_d   = div_q;
        irqen_d = irqen_q;
        ovf_d   = ovf_q;
        if (wr_en) begin
            case (sel)
                SEL_STATUS: begin
                    if (wmask_i[0] && data_i[ST_OVF]) ovf_d = 1'b0;
                end
                SEL_BAUDDIV: begin
                    if (wmask_i[0]) div_d[7:0]  = data_i[7:0];
                    if (wmask_i[1]) div_d[15:8] = data_i[15:8];
                end
                SEL_IRQEN: begin
                    if (wmask_i[0]) irqen_d = data_i[0];
                end
                default: ;
            endcase
        end
        if (push && fifo_full) ovf_d = 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    assign baud_done = (baud_q == '0);

    // FSM: next state and pop request
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: if (baud_done) state_d = DATA;
            DATA:  if (baud_done && bit_q == 3'd7) state_d = STOP;
            STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        tx_o  = 1'b1;
        busy  = (state_q != IDLE);
        irq_d = irqen_q & fifo_empty & (state_q == IDLE);
        case (state_q)
            START:   tx_o = 1'b0;
            DATA:    tx_o = shift_q[0];
            default: tx_o = 1'b1;
        endcase
    end

    // The divisor is sampled only when a bit begins, so a mid-frame write
    // never stretches or truncates the bit in flight.
    assign data_bit_end = (state_q == DATA) & baud_done;
    assign bit_start    = pop | (((state_q == START) | (state_q == DATA)) & baud_done);

    always_comb begin
        baud_d  = baud_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        if (bit_start)       baud_d = div_q;
        else if (!baud_done) baud_d = baud_q - 16'd1;
        if (pop) begin
            shift_d = fifo_dout;
            bit_d   = '0;
        end else if (data_bit_end) begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q   <= DEFAULT_DIV;
            irqen_q <= 1'b0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
            baud_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            div_q   <= div_d;
            irqen_q <= irqen_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

    assign irq_o = irq_q;

    always_comb begin
        data_o = '0;
        if (!csb_i) begin
            case (sel)
                SEL_STATUS: begin
                    data_o[ST_EMPTY] = fifo_empty;
                    data_o[ST_FULL]  = fifo_full;
                    data_o[ST_BUSY]  = busy;
                    data_o[ST_OVF]   = ovf_q;
                end
                SEL_BAUDDIV: data_o[15:0] = div_q;
                SEL_IRQEN:   data_o[0]    = irqen_q;
                default:     data_o       = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: randomized bus traffic checked
// against a frame-level reference model (queue of accepted bytes, expected
// 8N1 waveform per frame, FIFO occupancy from accepted minus started frames).
module tb_uart_tx_periph;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csb = 1'b1;
    logic        wen = 1'b1;
    logic [3:0]  addr = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx, irq;

    always #5 clk = ~clk;

    uart_tx_periph #(
        .FIFO_DEPTH(DEPTH),
        .DEFAULT_DIV(16'd867)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .csb_i   (csb),
        .wen_i   (wen),
        .addr_i  (addr),
        .data_i  (wdata),
        .wmask_i (wmask),
        .data_o  (rdata),
        .tx_o    (tx),
        .irq_o   (irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  q[$];
    int          acc = 0;
    int          started = 0;
    int          frames_done = 0;
    logic        ovf_m = 1'b0;
    logic [15:0] div_m = 16'd867;
    logic        irqen_m = 1'b0;
    logic        inframe = 1'b0;
    logic        busy_m = 1'b0;
    logic        must_start = 1'b0;
    logic        cond_prev = 1'b0;
    int          pos = 0;
    int          fdiv = 1;
    int          bidx = 0;
    logic        ebit;
    logic [7:0]  cur = '0;

    function automatic int occ();
        return acc - started;
    endfunction

    // Line monitor: decodes tx against the expected byte queue every cycle.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            inframe    = 1'b0;
            busy_m     = 1'b0;
            must_start = 1'b0;
            cond_prev  = 1'b0;
            check("rst_tx", {31'd0, tx}, 32'd1);
            check("rst_irq", {31'd0, irq}, 32'd0);
        end else begin
            check("irq", {31'd0, irq}, {31'd0, cond_prev});
            if (!inframe) begin
                if (must_start) check("gapless_start", {31'd0, tx}, 32'd0);
                if (tx == 1'b0) begin
                    if (q.size() == 0) begin
                        check("spurious_frame", {31'd0, tx}, 32'd1);
                    end else begin
                        cur     = q.pop_front();
                        started++;
                        inframe = 1'b1;
                        pos     = 0;
                        fdiv    = int'(div_m) + 1;
                    end
                end
            end
            busy_m = inframe;
            if (inframe) begin
                bidx = pos / fdiv;
                if (bidx == 0)      ebit = 1'b0;
                else if (bidx == 9) ebit = 1'b1;
                else                ebit = cur[bidx-1];
                check($sformatf("frame%0d_bit%0d", frames_done, bidx), {31'd0, tx}, {31'd0, ebit});
                pos++;
                if (pos == 10 * fdiv) begin
                    inframe = 1'b0;
                    frames_done++;
                end
            end
            must_start = !inframe && (q.size() != 0);
            cond_prev  = irqen_m && (occ() == 0) && !busy_m;
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        csb = 1'b0; wen = 1'b0; addr = a; wdata = d; wmask = m;
        case (a[3:2])
            2'd0: if (m[0]) begin
                if (occ() < int'(DEPTH)) begin
                    q.push_back(d[7:0]);
                    acc++;
                end else begin
                    ovf_m = 1'b1;
                end
            end
            2'd1: if (m[0] && d[3]) ovf_m = 1'b0;
            2'd2: begin
                if (m[0]) div_m[7:0]  = d[7:0];
                if (m[1]) div_m[15:8] = d[15:8];
            end
            default: if (m[0]) irqen_m = d[0];
        endcase
    endtask

    task automatic bus_idle();
        @(negedge clk);
        csb = 1'b1; wen = 1'b1; wmask = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        csb = 1'b0; wen = 1'b1; wmask = '0; addr = a;
        #1 d = rdata;
        csb = 1'b1;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] r;
        bus_read(4'h4, r);
        check(tag, r, {28'd0, ovf_m, busy_m, occ() == int'(DEPTH), occ() == 0});
    endtask

    task automatic drain(input string tag, input int limit);
        logic [31:0] r;
        int n = 0;
        bus_idle();
        while ((occ() != 0 || busy_m) && n < limit) begin
            check_status(tag);
            n++;
        end
        bus_read(4'h4, r);
        check({tag, "_idle"}, r, {28'd0, ovf_m, 3'b001});
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1; csb = 1'b1; wen = 1'b1; wmask = '0;
        q.delete();
        acc = 0; started = 0;
        ovf_m = 1'b0; div_m = 16'd867; irqen_m = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int base;

        // Reset state
        do_reset(2);
        check_status("rst_status");
        bus_read(4'h8, r); check("rst_bauddiv", r, 32'd867);
        bus_read(4'hC, r); check("rst_irqen", r, 32'd0);
        bus_read(4'h0, r); check("txdata_read", r, 32'd0);
        @(negedge clk); addr = 4'h8; csb = 1'b1; #1 check("deselect_read", rdata, 32'd0);
        check("rst_tx_o", {31'd0, tx}, 32'd1);
        check("rst_irq_o", {31'd0, irq}, 32'd0);

        // Single 0xA5 frame at BAUDDIV=3
        bus_write(4'h8, 32'd3, 4'b0011);
        bus_write(4'h0, 32'hA5, 4'b0001);
        drain("a5", 200);
        check("a5_frames", frames_done, 32'd1);

        // Burst of 11 at BAUDDIV=1: 9 accepted, overflow set, then cleared
        bus_write(4'h8, 32'd1, 4'b0011);
        base = frames_done;
        for (int i = 0; i < 11; i++) bus_write(4'h0, $urandom, 4'b0001);
        bus_idle();
        bus_read(4'h4, r); check("ovf_set", {31'd0, r[3]}, 32'd1);
        check_status("burst_status");
        bus_write(4'h4, 32'h8, 4'b0001);
        bus_idle();
        check_status("ovf_clear");
        drain("burst", 400);
        check("burst_frames", frames_done - base, 32'd9);

        // Interrupt behaviour
        bus_write(4'hC, 32'd1, 4'b0001);
        bus_idle();
        repeat (2) bus_idle();
        check("irq_idle_high", {31'd0, irq}, 32'd1);
        bus_write(4'h0, 32'h3C, 4'b0001);
        @(posedge clk); #1 check("irq_hold", {31'd0, irq}, 32'd1);
        bus_idle();
        @(posedge clk); #1 check("irq_drop", {31'd0, irq}, 32'd0);
        drain("irq", 200);
        repeat (2) bus_idle();
        check("irq_done", {31'd0, irq}, 32'd1);
        bus_write(4'hC, 32'd0, 4'b0001);
        bus_idle();
        @(posedge clk); #1 check("irq_disabled", {31'd0, irq}, 32'd0);

        // Byte masks
        bus_write(4'h8, 32'hFFFF_1234, 4'b0010);
        bus_idle();
        bus_read(4'h8, r); check("bauddiv_lane1", r, 32'h0000_1201);
        bus_write(4'h8, 32'd1, 4'b0011);
        bus_write(4'h0, 32'h55, 4'b1110);
        bus_idle();
        check_status("nopush_status");
        repeat (12) bus_idle();
        check("nopush_frames", frames_done, base + 32'd10);

        // Randomized traffic
        for (int b = 0; b < 4; b++) begin
            bus_write(4'h8, $urandom_range(0, 2), 4'b0011);
            if (b == 2) bus_write(4'hC, 32'd1, 4'b0001);
            for (int n = 0; n < 15; n++) begin
                case ($urandom_range(0, 7))
                    0:       bus_write(4'h0, $urandom, 4'b1110);
                    1:       bus_write(4'h4, 32'h8, 4'b0001);
                    2:       check_status("rand_mid");
                    default: bus_write(4'h0, $urandom, 4'b0001);
                endcase
                repeat ($urandom_range(0, 2)) bus_idle();
            end
            drain("rand", 2000);
        end

        // Reset in the middle of a DATA bit
        bus_write(4'hC, 32'd0, 4'b0001);
        bus_write(4'h8, 32'd3, 4'b0011);
        bus_write(4'h0, 32'hC3, 4'b0001);
        bus_write(4'h0, 32'h96, 4'b0001);
        repeat (12) bus_idle();
        check("midframe_busy", {31'd0, busy_m}, 32'd1);
        do_reset(1);
        check_status("post_reset_status");
        bus_read(4'h8, r); check("post_reset_div", r, 32'd867);
        repeat (40) bus_idle();
        check("post_reset_tx", {31'd0, tx}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
